// File: rtl/rx_symbol_deser.sv
// C-PHY receive symbol deserializer: hunts for the sync word, then packs every 7 accepted
// symbols into flip/rotation/polarity words. Optional macro DESER_RESYNC_EN re-aligns on in-band sync.
module rx_symbol_deser #(
  parameter logic [6:0] SYNC_FLIP = 7'b0111110,
  parameter logic [6:0] SYNC_ROT  = 7'b1000001,
  parameter logic [6:0] SYNC_POL  = 7'b1000001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       HsEn,
  input  logic       SymValid,
  input  logic       SymFlip,
  input  logic       SymRotation,
  input  logic       SymPolarity,
  output logic [6:0] RxFlip,
  output logic [6:0] RxRotation,
  output logic [6:0] RxPolarity,
  output logic       RxWordValid,
  output logic       RxSyncHS,
  output logic       RxLocked,
  output logic [1:0] DbgState
);

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Hunt   = 2'd1,
    Locked = 2'd2
  } state_t;

  state_t     state, stateNext;
  logic [6:0] shFlip, shRot, shPol;
  logic [6:0] winFlip, winRot, winPol;
  logic [2:0] symCnt;
  logic       accept;
  logic       winIsSync;

  // Handshake: SymValid is a one-cycle "symbol present" qualifier with no ready; a symbol is
  // consumed on any edge where SymValid=1, HsEn=1 and the FSM is hunting or locked, else it is lost.
  assign accept    = SymValid && HsEn && (state == Hunt || state == Locked);
  assign winFlip   = {shFlip[5:0], SymFlip};
  assign winRot    = {shRot[5:0], SymRotation};
  assign winPol    = {shPol[5:0], SymPolarity};
  assign winIsSync = (winFlip == SYNC_FLIP) && (winRot == SYNC_ROT) && (winPol == SYNC_POL);

  assign RxLocked = (state == Locked);
  assign DbgState = state;

  always_comb begin
    stateNext = state;
    case (state)
      Idle:    if (HsEn) stateNext = Hunt;
      Hunt:    if (!HsEn) stateNext = Idle;
               else if (accept && winIsSync) stateNext = Locked;
      Locked:  if (!HsEn) stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= Idle;
      shFlip      <= '0;
      shRot       <= '0;
      shPol       <= '0;
      symCnt      <= '0;
      RxFlip      <= '0;
      RxRotation  <= '0;
      RxPolarity  <= '0;
      RxWordValid <= 1'b0;
      RxSyncHS    <= 1'b0;
    end else begin
      state       <= stateNext;
      RxWordValid <= 1'b0;
      RxSyncHS    <= 1'b0;
      if (!HsEn || state == Idle) begin
        // Leaving the burst drops any partial word; field outputs keep the last word.
        shFlip <= '0;
        shRot  <= '0;
        shPol  <= '0;
        symCnt <= '0;
      end else if (accept) begin
        shFlip <= winFlip;
        shRot  <= winRot;
        shPol  <= winPol;
        if (state == Hunt) begin
          if (winIsSync) begin
            RxSyncHS <= 1'b1;
            symCnt   <= '0;
          end
        end else if (symCnt == 3'd6) begin
          symCnt <= '0;
`ifdef DESER_RESYNC_EN
          if (winIsSync) begin
            RxSyncHS <= 1'b1;
          end else begin
            RxFlip      <= winFlip;
            RxRotation  <= winRot;
            RxPolarity  <= winPol;
            RxWordValid <= 1'b1;
          end
`else
          RxFlip      <= winFlip;
          RxRotation  <= winRot;
          RxPolarity  <= winPol;
          RxWordValid <= 1'b1;
`endif
        end else begin
          symCnt <= symCnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_symbol_deser.sv
// Testbench for rx_symbol_deser: scenario tasks plus randomized bursts, all checked against a
// symbol-history reference model. Honors DESER_RESYNC_EN when compiled with it.
module tb_rx_symbol_deser;

  localparam logic [6:0] S_FLIP = 7'b0111110;
  localparam logic [6:0] S_ROT  = 7'b1000001;
  localparam logic [6:0] S_POL  = 7'b1000001;
  localparam logic [20:0] SYNC_WORD = {S_FLIP, S_ROT, S_POL};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       HsEn = 1'b0, SymValid = 1'b0;
  logic       SymFlip = 1'b0, SymRotation = 1'b0, SymPolarity = 1'b0;
  logic [6:0] RxFlip, RxRotation, RxPolarity;
  logic       RxWordValid, RxSyncHS, RxLocked;
  logic [1:0] DbgState;

  rx_symbol_deser dut (
    .clk(clk), .rst(rst), .HsEn(HsEn), .SymValid(SymValid),
    .SymFlip(SymFlip), .SymRotation(SymRotation), .SymPolarity(SymPolarity),
    .RxFlip(RxFlip), .RxRotation(RxRotation), .RxPolarity(RxPolarity),
    .RxWordValid(RxWordValid), .RxSyncHS(RxSyncHS), .RxLocked(RxLocked),
    .DbgState(DbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: mode 0=idle 1=hunting 2=locked, plus history of accepted symbols
  int         m_mode = 0;
  logic [2:0] hist[$];
  int         m_data_cnt = 0;
  logic [6:0] e_flip = '0, e_rot = '0, e_pol = '0;
  logic       e_wv = 1'b0, e_sync = 1'b0, e_locked = 1'b0;

  // observations from the DUT
  logic [20:0] obs_q[$];
  logic [20:0] exp_q[$];
  int          sync_seen = 0;

  typedef struct { logic hs; logic v; logic [2:0] sym; } stim_t;
  stim_t sq[$];

  function automatic logic [20:0] model_window();
    logic [6:0] f, r, p;
    f = '0; r = '0; p = '0;
    for (int i = 0; i < 7; i++) begin
      int idx;
      idx = hist.size() - 1 - i;
      if (idx >= 0) {f[i], r[i], p[i]} = hist[idx];
    end
    return {f, r, p};
  endfunction

  task automatic model_step();
    logic [20:0] w;
    e_wv = 1'b0;
    e_sync = 1'b0;
    if (rst) begin
      m_mode = 0; hist.delete(); m_data_cnt = 0;
      e_flip = '0; e_rot = '0; e_pol = '0;
    end else if (!HsEn) begin
      m_mode = 0; hist.delete(); m_data_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (SymValid) begin
      hist.push_back({SymFlip, SymRotation, SymPolarity});
      if (hist.size() > 7) void'(hist.pop_front());
      w = model_window();
      if (m_mode == 1) begin
        if (w == SYNC_WORD) begin
          e_sync = 1'b1; m_mode = 2; m_data_cnt = 0;
        end
      end else begin
        m_data_cnt++;
        if (m_data_cnt == 7) begin
          m_data_cnt = 0;
`ifdef DESER_RESYNC_EN
          if (w == SYNC_WORD) e_sync = 1'b1;
          else begin {e_flip, e_rot, e_pol} = w; e_wv = 1'b1; end
`else
          {e_flip, e_rot, e_pol} = w;
          e_wv = 1'b1;
`endif
        end
      end
    end
    e_locked = (m_mode == 2);
  endtask

  // driver: apply one cycle of inputs, advance the model, sample #1 after the edge
  task automatic drive_cycle(input logic hs, input logic v, input logic [2:0] sym);
    HsEn = hs;
    SymValid = v;
    {SymFlip, SymRotation, SymPolarity} = sym;
    @(posedge clk);
    model_step();
    #1;
    if (RxWordValid) obs_q.push_back({RxFlip, RxRotation, RxPolarity});
    if (RxSyncHS) sync_seen++;
  endtask

  // stimulus builders
  function automatic void add_sym(input logic [2:0] sym, input bit gapped);
    sq.push_back('{hs: 1'b1, v: 1'b1, sym: sym});
    if (gapped) sq.push_back('{hs: 1'b1, v: 1'b0, sym: 3'($urandom_range(0, 7))});
  endfunction

  function automatic void add_word(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p,
                                   input bit gapped);
    for (int i = 6; i >= 0; i--) add_sym({f[i], r[i], p[i]}, gapped);
  endfunction

  function automatic void add_burst_start(input int pre, input bit gapped);
    sq.push_back('{hs: 1'b1, v: 1'b0, sym: 3'd0});
    for (int i = 0; i < pre; i++) add_sym(3'd3, gapped);
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) sq.push_back('{hs: 1'b0, v: 1'b0, sym: 3'd0});
  endfunction

  function automatic void clear_run();
    sq.delete(); obs_q.delete(); exp_q.delete(); sync_seen = 0;
  endfunction

  task automatic test_reset();
    clear_run();
    drive_cycle(1'b0, 1'b0, 3'd0);
    drive_cycle(1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    add_burst_start(9, 1'b0);
    add_word(S_FLIP, S_ROT, S_POL, 1'b0);
    add_sym(3'd5, 1'b0); add_sym(3'd1, 1'b0);
    foreach (sq[i]) begin
      drive_cycle(sq[i].hs, sq[i].v, sq[i].sym);
      checks++;
      if ({RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked} !==
          {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked}) begin
        errors++;
        $display("FAIL reset_prelude cyc=%0d got=%h exp=%h", i,
                 {RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked},
                 {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked});
      end
    end
    checks++;
    if (RxLocked !== 1'b1) begin
      errors++; $display("FAIL reset_locked_before got=%b exp=1", RxLocked);
    end
    rst = 1'b1;
    drive_cycle(1'b1, 1'b1, 3'd4);
    drive_cycle(1'b1, 1'b1, 3'd4);
    checks++;
    if ({RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked, DbgState} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0",
               {RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked, DbgState});
    end
    rst = 1'b0;
    drive_cycle(1'b1, 1'b1, 3'd3);
    checks++;
    if (DbgState !== 2'd1 || RxLocked !== 1'b0) begin
      errors++; $display("FAIL reset_to_hunt got=%0d/%b exp=1/0", DbgState, RxLocked);
    end
    drive_cycle(1'b0, 1'b0, 3'd0);
  endtask

  // preamble + sync + one data word, optionally with SymValid gaps
  task automatic test_word(input bit gapped);
    int sync_last, sync_at;
    clear_run();
    add_burst_start(9, gapped);
    add_word(S_FLIP, S_ROT, S_POL, 1'b0);
    sync_last = sq.size() - 1;
    if (gapped) sq.push_back('{hs: 1'b1, v: 1'b0, sym: 3'd7});
    add_word(7'h0a, 7'b1100110, 7'b1111000, gapped);
    add_idle(2);
    exp_q.push_back({7'h0a, 7'b1100110, 7'b1111000});
    sync_at = -1;
    foreach (sq[i]) begin
      drive_cycle(sq[i].hs, sq[i].v, sq[i].sym);
      if (RxSyncHS) sync_at = i;
      checks++;
      if ({RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked} !==
          {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked}) begin
        errors++;
        $display("FAIL word_cycle gapped=%0d cyc=%0d got=%h exp=%h", gapped, i,
                 {RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked},
                 {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked});
      end
    end
    checks++;
    if (sync_at != sync_last || sync_seen != 1) begin
      errors++;
      $display("FAIL word_sync_timing gapped=%0d got=%0d(n=%0d) exp=%0d(n=1)", gapped, sync_at,
               sync_seen, sync_last);
    end
    checks++;
    if (obs_q.size() != exp_q.size() || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL word_fields gapped=%0d got=%0d words first=%h exp=1 word %h", gapped,
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 21'h0, exp_q[0]);
    end
  endtask

  task automatic test_abort();
    logic [20:0] prev;
    int abort_idx;
    clear_run();
    prev = {RxFlip, RxRotation, RxPolarity};
    add_burst_start(5, 1'b0);
    add_word(S_FLIP, S_ROT, S_POL, 1'b0);
    for (int i = 0; i < 4; i++) add_sym(3'($urandom_range(0, 7)), 1'b0);
    abort_idx = sq.size();
    add_idle(2);
    add_burst_start(9, 1'b0);
    add_word(S_FLIP, S_ROT, S_POL, 1'b0);
    add_word(7'h20, 7'b0000111, 7'b0110001, 1'b0);
    add_idle(2);
    exp_q.push_back({7'h20, 7'b0000111, 7'b0110001});
    foreach (sq[i]) begin
      drive_cycle(sq[i].hs, sq[i].v, sq[i].sym);
      checks++;
      if ({RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked} !==
          {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked}) begin
        errors++;
        $display("FAIL abort_cycle cyc=%0d got=%h exp=%h", i,
                 {RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked},
                 {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked});
      end
      if (i == abort_idx) begin
        checks++;
        if (RxLocked !== 1'b0 || {RxFlip, RxRotation, RxPolarity} !== prev || obs_q.size() != 0) begin
          errors++;
          $display("FAIL abort_drop got lock=%b fields=%h words=%0d exp lock=0 fields=%h words=0",
                   RxLocked, {RxFlip, RxRotation, RxPolarity}, obs_q.size(), prev);
        end
      end
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL abort_new_word got=%0d words first=%h exp=1 word %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 21'h0, exp_q[0]);
    end
  endtask

  task automatic test_mid_sync();
    int exp_sync;
    clear_run();
    add_burst_start(9, 1'b0);
    add_word(S_FLIP, S_ROT, S_POL, 1'b0);
    add_word(7'h55, 7'h2a, 7'h0f, 1'b0);
    add_word(S_FLIP, S_ROT, S_POL, 1'b0);
    add_word(7'h13, 7'h64, 7'h39, 1'b0);
    add_idle(2);
    exp_q.push_back({7'h55, 7'h2a, 7'h0f});
`ifdef DESER_RESYNC_EN
    exp_sync = 2;
`else
    exp_sync = 1;
    exp_q.push_back(SYNC_WORD);
`endif
    exp_q.push_back({7'h13, 7'h64, 7'h39});
    foreach (sq[i]) begin
      drive_cycle(sq[i].hs, sq[i].v, sq[i].sym);
      checks++;
      if ({RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked} !==
          {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked}) begin
        errors++;
        $display("FAIL midsync_cycle cyc=%0d got=%h exp=%h", i,
                 {RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked},
                 {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked});
      end
    end
    checks++;
    if (sync_seen != exp_sync) begin
      errors++; $display("FAIL midsync_sync_count got=%0d exp=%0d", sync_seen, exp_sync);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midsync_word_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL midsync_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_no_sync();
    int bad;
    clear_run();
    add_burst_start(50, 1'b0);
    add_idle(1);
    bad = 0;
    foreach (sq[i]) begin
      drive_cycle(sq[i].hs, sq[i].v, sq[i].sym);
      if (RxLocked !== 1'b0 || RxSyncHS !== 1'b0 || RxWordValid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL nosync_quiet got=%0d active cycles exp=0", bad);
    end
  endtask

  task automatic test_random();
    int bad;
    clear_run();
    for (int b = 0; b < 12; b++) begin
      add_burst_start($urandom_range(0, 12), 1'b0);
      for (int s = 0; s < 120; s++) begin
        if ($urandom_range(0, 29) == 0) add_word(S_FLIP, S_ROT, S_POL, 1'b0);
        if ($urandom_range(0, 3) == 0) sq.push_back('{hs: 1'b1, v: 1'b0, sym: 3'($urandom_range(0, 7))});
        else add_sym(3'($urandom_range(0, 7)), 1'b0);
      end
      add_idle($urandom_range(1, 3));
    end
    bad = 0;
    foreach (sq[i]) begin
      drive_cycle(sq[i].hs, sq[i].v, sq[i].sym);
      checks++;
      if ({RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked} !==
          {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle cyc=%0d got=%h exp=%h", i,
                   {RxFlip, RxRotation, RxPolarity, RxWordValid, RxSyncHS, RxLocked},
                   {e_flip, e_rot, e_pol, e_wv, e_sync, e_locked});
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_word(1'b0);
    test_word(1'b1);
    test_abort();
    test_mid_sync();
    test_no_sync();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_symbol_deser.md
# rx_symbol_deser

Receive-side C-PHY symbol deserializer for the slave HS path. It accepts one decoded 3-bit symbol per UI as flip, rotation and polarity bits. It hunts for the sync word, then packs each following group of 7 symbols into the 7-bit `RxFlip`/`RxRotation`/`RxPolarity` fields. It sits directly upstream of `demapper`, and its word outputs connect to the demapper field inputs one-to-one.

## Interface
- `SYNC_FLIP`, default 7'b0111110: flip field of the sync word 3444443.
- `SYNC_ROT`, default 7'b1000001: rotation field of the sync word.
- `SYNC_POL`, default 7'b1000001: polarity field of the sync word.
- `clk`  in  1  receive clock.
- `rst`  in  1  synchronous reset, active-high.
- `HsEn`  in  1  HS burst active; low means LP/idle.
- `SymValid`  in  1  one decoded symbol present this cycle.
- `SymFlip`  in  1  flip bit of the current symbol.
- `SymRotation`  in  1  rotation bit of the current symbol.
- `SymPolarity`  in  1  polarity bit of the current symbol.
- `RxFlip`  out  7  flip field of the assembled word.
- `RxRotation`  out  7  rotation field of the assembled word.
- `RxPolarity`  out  7  polarity field of the assembled word.
- `RxWordValid`  out  1  one-cycle strobe: new word on the field outputs.
- `RxSyncHS`  out  1  one-cycle strobe: sync word detected.
- `RxLocked`  out  1  high while in LOCKED.

## Operation
- Symbol acceptance: a symbol is accepted when `SymValid`=1, `HsEn`=1 and state is HUNT or LOCKED.
- Shift register: three 7-bit shift registers, one per field, load on each accepted symbol.
  - The first-received symbol ends in bit 6; the newest symbol enters bit 0.
  - Window after a shift = `{old[5:0], new}` per field.
  - All comparisons use the post-shift window.
- State IDLE:
  - Shift registers and symbol counter held at 0.
  - Goes to HUNT on the cycle after `HsEn`=1 is seen.
  - Symbols presented in IDLE are ignored; preamble loss is harmless.
- State HUNT:
  - Every accepted symbol updates the window.
  - If the window equals (`SYNC_FLIP`, `SYNC_ROT`, `SYNC_POL`): pulse `RxSyncHS`, clear the symbol counter, go to LOCKED.
  - The sync word is never emitted as data.
- State LOCKED:
  - 3-bit symbol counter counts 0..6 on accepted symbols.
  - On the accept with counter = 6: latch the window into `RxFlip`/`RxRotation`/`RxPolarity`, pulse `RxWordValid`, wrap the counter to 0.
  - Field outputs hold their last word between strobes.
- Any state, `HsEn`=0:
  - Next state is IDLE; the counter and shift registers clear.
  - A partial word is discarded with no strobe.
  - The field outputs keep the last word.
- Simultaneous `HsEn`=0 and `SymValid`=1: `HsEn` wins and the symbol is dropped.
- Gaps in `SymValid` within a burst do not break word framing.

## Timing
- Reset: state IDLE, counter 0, shift registers 0, `RxFlip`/`RxRotation`/`RxPolarity`=0, `RxWordValid`=0, `RxSyncHS`=0, `RxLocked`=0.
- Reset asserted mid-burst overrides everything on the next edge, and the block restarts in IDLE.
- Latency: `RxWordValid`, the field outputs and `RxSyncHS` are registered. Each is valid 1 cycle after the clock edge that accepts the 7th symbol.
- `RxLocked` rises together with the `RxSyncHS` pulse and falls 1 cycle after `HsEn` is sampled low.
- Throughput: at most one word per 7 accepted symbols, and at most one symbol per cycle.
- There is no back-pressure; the downstream demapper captures every `RxWordValid`.

## Configuration
- `DESER_RESYNC_EN` defined: in LOCKED, a completed word equal to the sync word produces:
  - a `RxSyncHS` pulse;
  - no `RxWordValid`;
  - field outputs left unchanged;
  - counter re-aligned to 0.
- `DESER_RESYNC_EN` undefined: such a word is emitted as ordinary data with `RxWordValid`, and `RxSyncHS` pulses only in HUNT.

## Test plan
- Reset: assert `rst` for 2 cycles during a burst -> all outputs 0 and state IDLE on the following cycle.
- Basic word:
  - Stimulus: `HsEn`=1, 9 × symbol 3 (f0 r1 p1), then sync 3444443, then 7 symbols forming `RxFlip`=7'h0a, `RxRotation`=7'b1100110, `RxPolarity`=7'b1111000 (bit 6 sent first).
  - Response: `RxSyncHS` pulses 1 cycle after the last sync symbol.
  - Response: `RxWordValid`=1 with exactly those fields 1 cycle after the 7th data symbol.
- Gapped input: same burst with `SymValid` low on every other cycle -> identical words and strobes, with no extra strobes.
- Burst abort:
  - Stimulus: drop `HsEn` after 4 data symbols.
  - Response: no `RxWordValid`, `RxLocked`=0 next cycle, fields still hold the previous word.
  - Stimulus: a new burst with preamble + sync + word `RxFlip`=7'h20, `RxRotation`=7'b0000111, `RxPolarity`=7'b0110001.
  - Response: that word is emitted correctly.
- Mid-burst sync:
  - Stimulus: in LOCKED, send a sync word followed by a data word.
  - With `DESER_RESYNC_EN`: one `RxSyncHS` pulse, no strobe for the sync word, then one data strobe.
  - Without `DESER_RESYNC_EN`: two `RxWordValid` strobes; the first carries fields 7'b0111110 / 7'b1000001 / 7'b1000001.
- No sync in HUNT: 50 symbols of 3 with `HsEn`=1 -> `RxLocked`, `RxSyncHS` and `RxWordValid` stay 0 throughout.
